// File: rtl/branch_redirect_ctrl.sv
// EX-stage branch resolution: detects mispredicts, flushes, holds the IFU redirect and pulses predictor updates.
// Optional performance counters are enabled by defining BRC_PERF_EN.
module branch_redirect_ctrl #(
    parameter int XLEN       = 32,
    parameter int INST_BYTES = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            ex_valid,
    output logic            ex_ready,
    input  logic            ex_is_jump,
    input  logic [XLEN-1:0] ex_pc,
    input  logic            ex_pred_taken,
    input  logic [XLEN-1:0] ex_pred_target,
    input  logic            bru_taken,
    input  logic [XLEN-1:0] bru_target,
    input  logic            ext_flush,
    output logic            flush,
    output logic            redir_valid,
    output logic [XLEN-1:0] redir_pc,
    input  logic            redir_ready,
    output logic            upd_valid,
    output logic [XLEN-1:0] upd_pc,
    output logic            upd_taken,
    output logic [XLEN-1:0] upd_target
`ifdef BRC_PERF_EN
    ,
    output logic [31:0]     perf_branches,
    output logic [31:0]     perf_mispred
`endif
);

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        REDIR = 1'b1
    } state_t;

    state_t          state_r;
    logic            accept_s;
    logic [XLEN-1:0] seq_pc_s;
    logic [XLEN-1:0] act_next_s;
    logic [XLEN-1:0] pred_next_s;
    logic            mispred_s;

    // Resolved vs predicted next PC; bru_* only matter for control-flow instructions.
    always_comb begin
        seq_pc_s = ex_pc + XLEN'(INST_BYTES);
        if (ex_is_jump && bru_taken) begin
            act_next_s = bru_target;
        end else begin
            act_next_s = seq_pc_s;
        end
        if (ex_pred_taken) begin
            pred_next_s = ex_pred_target;
        end else begin
            pred_next_s = seq_pc_s;
        end
        mispred_s = (act_next_s != pred_next_s);
    end

    // EX handshake; a late-stage flush squashes the instruction being offered.
    always_comb begin
        ex_ready = (state_r == IDLE);
        accept_s = ex_valid && ex_ready && !ext_flush;
    end

    // Controller FSM with registered flush, redirect and predictor-update outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= IDLE;
            flush       <= 1'b0;
            redir_valid <= 1'b0;
            redir_pc    <= {XLEN{1'b0}};
            upd_valid   <= 1'b0;
            upd_pc      <= {XLEN{1'b0}};
            upd_taken   <= 1'b0;
            upd_target  <= {XLEN{1'b0}};
        end else begin
            flush     <= 1'b0;
            upd_valid <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (accept_s && ex_is_jump) begin
                        upd_valid  <= 1'b1;
                        upd_pc     <= ex_pc;
                        upd_taken  <= bru_taken;
                        upd_target <= bru_target;
                    end
                    if (accept_s && mispred_s) begin
                        flush       <= 1'b1;
                        redir_valid <= 1'b1;
                        redir_pc    <= act_next_s;
                        state_r     <= REDIR;
                    end
                end
                REDIR: begin
                    // A later-stage flush owns the PC, so the pending redirect is simply dropped.
                    if (ext_flush || redir_ready) begin
                        redir_valid <= 1'b0;
                        state_r     <= IDLE;
                    end
                end
                default: begin
                    redir_valid <= 1'b0;
                    state_r     <= IDLE;
                end
            endcase
        end
    end

`ifdef BRC_PERF_EN
    // Free-running event counters, cleared only by reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            perf_branches <= 32'd0;
            perf_mispred  <= 32'd0;
        end else begin
            if (accept_s && ex_is_jump) begin
                perf_branches <= perf_branches + 32'd1;
            end
            if (accept_s && mispred_s) begin
                perf_mispred <= perf_mispred + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_branch_redirect_ctrl.sv
// Scoreboard bench for branch_redirect_ctrl: a cycle model pushes expected outputs, compared after each edge.
module tb_branch_redirect_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        ex_valid = 1'b0;
    logic        ex_ready;
    logic        ex_is_jump = 1'b0;
    logic [31:0] ex_pc = 32'd0;
    logic        ex_pred_taken = 1'b0;
    logic [31:0] ex_pred_target = 32'd0;
    logic        bru_taken = 1'b0;
    logic [31:0] bru_target = 32'd0;
    logic        ext_flush = 1'b0;
    logic        flush;
    logic        redir_valid;
    logic [31:0] redir_pc;
    logic        redir_ready = 1'b0;
    logic        upd_valid;
    logic [31:0] upd_pc;
    logic        upd_taken;
    logic [31:0] upd_target;
`ifdef BRC_PERF_EN
    logic [31:0] perf_branches;
    logic [31:0] perf_mispred;
`endif

    branch_redirect_ctrl #(.XLEN(32), .INST_BYTES(4)) dut (
        .clk(clk), .rst(rst),
        .ex_valid(ex_valid), .ex_ready(ex_ready), .ex_is_jump(ex_is_jump), .ex_pc(ex_pc),
        .ex_pred_taken(ex_pred_taken), .ex_pred_target(ex_pred_target),
        .bru_taken(bru_taken), .bru_target(bru_target), .ext_flush(ext_flush),
        .flush(flush), .redir_valid(redir_valid), .redir_pc(redir_pc), .redir_ready(redir_ready),
        .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_taken(upd_taken), .upd_target(upd_target)
`ifdef BRC_PERF_EN
        , .perf_branches(perf_branches), .perf_mispred(perf_mispred)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        flush;
        logic        redir_valid;
        logic [31:0] redir_pc;
        logic        upd_valid;
        logic [31:0] upd_pc;
        logic        upd_taken;
        logic [31:0] upd_target;
        logic        ex_ready;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    // Reference model state
    logic        m_redir = 1'b0;
    exp_t        m;
    logic [31:0] m_branches = 32'd0;
    logic [31:0] m_mispred  = 32'd0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] want);
        n_checks++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, want);
        end
    endtask

    // Drive one cycle of stimulus, push the model's prediction, then compare after the edge.
    task automatic step(input logic r, input logic v, input logic j, input logic [31:0] pc,
                        input logic pt, input logic [31:0] ptgt, input logic bt,
                        input logic [31:0] btgt, input logic ef, input logic rr);
        logic [31:0] seq, act, pred;
        logic        acc;
        exp_t        e;
        @(negedge clk);
        rst = r; ex_valid = v; ex_is_jump = j; ex_pc = pc; ex_pred_taken = pt;
        ex_pred_target = ptgt; bru_taken = bt; bru_target = btgt; ext_flush = ef; redir_ready = rr;
        check_eq("ex_ready_pre", {63'd0, ex_ready}, {63'd0, !m_redir});
        seq  = pc + 32'd4;
        act  = (j && bt) ? btgt : seq;
        pred = pt ? ptgt : seq;
        acc  = v && !m_redir && !ef;
        m.flush = 1'b0;
        m.upd_valid = 1'b0;
        if (r) begin
            m = '{1'b0, 1'b0, 32'd0, 1'b0, 32'd0, 1'b0, 32'd0, 1'b1};
            m_redir = 1'b0;
            m_branches = 32'd0;
            m_mispred = 32'd0;
        end else if (!m_redir) begin
            if (acc && j) begin
                m.upd_valid = 1'b1; m.upd_pc = pc; m.upd_taken = bt; m.upd_target = btgt;
                m_branches++;
            end
            if (acc && (act != pred)) begin
                m.flush = 1'b1; m.redir_valid = 1'b1; m.redir_pc = act;
                m_redir = 1'b1;
                m_mispred++;
            end
        end else if (ef || rr) begin
            m.redir_valid = 1'b0;
            m_redir = 1'b0;
        end
        m.ex_ready = !m_redir;
        exp_q.push_back(m);
        @(posedge clk);
        #1;
        e = exp_q.pop_front();
        check_eq("flush", {63'd0, flush}, {63'd0, e.flush});
        check_eq("redir_valid", {63'd0, redir_valid}, {63'd0, e.redir_valid});
        check_eq("redir_pc", {32'd0, redir_pc}, {32'd0, e.redir_pc});
        check_eq("upd_valid", {63'd0, upd_valid}, {63'd0, e.upd_valid});
        if (e.upd_valid) begin
            check_eq("upd_pc", {32'd0, upd_pc}, {32'd0, e.upd_pc});
            check_eq("upd_taken", {63'd0, upd_taken}, {63'd0, e.upd_taken});
            check_eq("upd_target", {32'd0, upd_target}, {32'd0, e.upd_target});
        end
        check_eq("ex_ready", {63'd0, ex_ready}, {63'd0, e.ex_ready});
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0, 1'b0, 32'd0, 1'b0, 1'b0);
    endtask

    initial begin
        m = '{1'b0, 1'b0, 32'd0, 1'b0, 32'd0, 1'b0, 32'd0, 1'b1};
        // Reset then idle; all outputs must read as the reset values.
        step(1'b1, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0, 1'b0, 32'd0, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0, 1'b0, 32'd0, 1'b0, 1'b0);
        check_eq("rst_upd_pc", {32'd0, upd_pc}, 64'd0);
        check_eq("rst_upd_target", {32'd0, upd_target}, 64'd0);
        idle(5);
        // Correctly predicted not-taken beq.
        step(1'b0, 1'b1, 1'b1, 32'h8000_0010, 1'b0, 32'd0, 1'b0, 32'h8000_0050, 1'b0, 1'b0);
        idle(1);
        // Mispredicted jal, IFU stalls 3 cycles while EX keeps offering an instruction.
        step(1'b0, 1'b1, 1'b1, 32'h8000_0000, 1'b0, 32'd0, 1'b1, 32'h8000_0100, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++)
            step(1'b0, 1'b1, 1'b1, 32'h8000_0100, 1'b0, 32'd0, 1'b1, 32'h8000_0300, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0, 1'b0, 32'd0, 1'b0, 1'b1);
        idle(1);
        // Taken with wrong predicted target.
        step(1'b0, 1'b1, 1'b1, 32'h8000_0100, 1'b1, 32'h8000_0200, 1'b1, 32'h8000_0204, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0, 1'b0, 32'd0, 1'b0, 1'b1);
        // Correctly predicted taken.
        step(1'b0, 1'b1, 1'b1, 32'h8000_0400, 1'b1, 32'h8000_0800, 1'b1, 32'h8000_0800, 1'b0, 1'b0);
        // Non-jump predicted taken at the top of memory: redirect wraps to 0, bru ignored.
        step(1'b0, 1'b1, 1'b0, 32'hFFFF_FFFC, 1'b1, 32'h0000_0010, 1'b1, 32'hDEAD_BEEF, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0, 1'b0, 32'd0, 1'b0, 1'b1);
        // ext_flush in IDLE suppresses a mispredicting accept.
        step(1'b0, 1'b1, 1'b1, 32'h8000_1000, 1'b0, 32'd0, 1'b1, 32'h8000_2000, 1'b1, 1'b0);
        // ext_flush in REDIR together with redir_ready.
        step(1'b0, 1'b1, 1'b1, 32'h8000_1000, 1'b0, 32'd0, 1'b1, 32'h8000_2000, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0, 1'b0, 32'd0, 1'b1, 1'b1);
        idle(2);
`ifdef BRC_PERF_EN
        check_eq("perf_branches", {32'd0, perf_branches}, {32'd0, m_branches});
        check_eq("perf_mispred", {32'd0, perf_mispred}, {32'd0, m_mispred});
`endif
        // Reset in the middle of a redirect.
        step(1'b0, 1'b1, 1'b1, 32'h8000_3000, 1'b0, 32'd0, 1'b1, 32'h8000_4000, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0, 1'b0, 32'd0, 1'b0, 1'b0);
        idle(1);
        // Randomised traffic over a small set of targets.
        for (int i = 0; i < 200; i++) begin
            logic [31:0] pc, pt, bt;
            pc = 32'h8000_0000 + {28'd0, 4'($urandom_range(0, 3)), 2'b00} * 32'd4;
            pt = pc + {30'd0, 2'($urandom_range(1, 2))} * 32'd4;
            bt = pc + {30'd0, 2'($urandom_range(1, 2))} * 32'd4;
            step(1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), pc,
                 1'($urandom_range(0, 1)), pt, 1'($urandom_range(0, 1)), bt,
                 ($urandom_range(0, 9) == 0), 1'($urandom_range(0, 1)));
        end
`ifdef BRC_PERF_EN
        check_eq("perf_branches_end", {32'd0, perf_branches}, {32'd0, m_branches});
        check_eq("perf_mispred_end", {32'd0, perf_mispred}, {32'd0, m_mispred});
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/branch_redirect_ctrl.md
Name: branch_redirect_ctrl

Overview:
Sequences branch resolution at the EX stage. Accepts each resolved control-flow result from the branch unit and compares it against the fetch-time prediction. On a mismatch it issues a one-cycle pipeline flush and holds a redirect request to the IFU until the IFU accepts it. It also emits a one-cycle predictor-update pulse for every resolved jump or branch, and stalls EX while a redirect is outstanding.

Parameters:
XLEN, 32, datapath/PC width
INST_BYTES, 4, sequential PC increment

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
ex_valid  in  1  EX holds an instruction to resolve
ex_ready  out  1  controller can accept (handshake with ex_valid)
ex_is_jump  in  1  instruction is jal/jalr/any branch (OR of jump_type bits)
ex_pc  in  XLEN  PC of EX instruction
ex_pred_taken  in  1  fetch-time prediction: taken
ex_pred_target  in  XLEN  fetch-time predicted target
bru_taken  in  1  branch unit resolved taken
bru_target  in  XLEN  branch unit resolved target
ext_flush  in  1  flush from a later stage (trap/mret); highest priority
flush  out  1  one-cycle squash of IF/ID and EX-younger state
redir_valid  out  1  redirect request to IFU
redir_pc  out  XLEN  redirect PC
redir_ready  in  1  IFU accepts redirect
upd_valid  out  1  one-cycle predictor update pulse
upd_pc  out  XLEN  PC being updated
upd_taken  out  1  resolved direction
upd_target  out  XLEN  resolved target

Behaviour:
- Clock is clk; reset is rst, synchronous and active-high.
- All outputs are registered except ex_ready.
- Reset: state=IDLE; flush=0, redir_valid=0, redir_pc=0, upd_valid=0, upd_pc=0, upd_taken=0, upd_target=0.
- States:
  - IDLE: ex_ready=1.
  - REDIR: ex_ready=0.
- Accept occurs when ex_valid && ex_ready && !ext_flush.
- Next-PC computation (all sums modulo 2^XLEN, wrap allowed):
  - act_next = (ex_is_jump && bru_taken) ? bru_target : ex_pc+INST_BYTES
  - pred_next = ex_pred_taken ? ex_pred_target : ex_pc+INST_BYTES
  - mispredict = (act_next != pred_next). A non-jump with ex_pred_taken=1 and target != pc+4 counts as a mispredict.
- Accept with mispredict in cycle N:
  - cycle N+1: flush=1 for exactly one cycle; redir_valid=1; redir_pc=act_next; state=REDIR.
- Accept without mispredict: no flush, no redirect, state stays IDLE.
- Predictor update on accept with ex_is_jump=1:
  - cycle N+1: upd_valid=1 for one cycle, with upd_pc=ex_pc, upd_taken=bru_taken, upd_target=bru_target.
  - Independent of mispredict. No update for non-jumps.
- REDIR state:
  - redir_valid and redir_pc are held stable until redir_ready=1.
  - Handshake in cycle M: redir_valid=0 and state=IDLE in M+1. A new accept is possible in M+1 at the earliest.
- ext_flush:
  - In IDLE: suppresses accept, so no flush, redirect or update from EX that cycle.
  - In REDIR: drops the pending redirect (redir_valid=0 next cycle, state=IDLE) even if redir_ready=1 in the same cycle. The later stage owns the PC.
- ex_valid=0: no action, outputs hold their idle values (pulses deassert).
- rst asserted mid-REDIR: next cycle matches the reset state; the redirect is lost.
- X-safety: bru_* are ignored when ex_is_jump=0.

Optional Feature:
Macro BRC_PERF_EN.
- Defined:
  - adds outputs perf_branches (32) and perf_mispred (32), both reset to 0.
  - perf_branches increments on each accept with ex_is_jump=1.
  - perf_mispred increments on each accept with mispredict=1.
  - Both wrap at 2^32 and are not cleared by ext_flush.
- Undefined: the ports and counters are absent; the remaining behaviour is identical.

Test Plan:
- Reset, then idle: all outputs 0, ex_ready=1 for 5 cycles.
- Correctly predicted not-taken beq: ex_pc=0x80000010, pred_taken=0, bru_taken=0 -> no flush/redir; upd_valid pulse with upd_pc=0x80000010, upd_taken=0.
- Mispredicted jal: ex_pc=0x80000000, pred_taken=0, bru_taken=1, bru_target=0x80000100, redir_ready=0 for 3 cycles -> flush high 1 cycle; redir_valid=1 with redir_pc=0x80000100 held 4 cycles; ex_ready=0 throughout; IDLE the cycle after redir_ready=1.
- Wrong target: pred_taken=1, pred_target=0x80000200, bru_taken=1, bru_target=0x80000204 -> redirect to 0x80000204.
- Non-jump predicted taken: ex_is_jump=0, ex_pc=0xFFFFFFFC, pred_taken=1, pred_target=0x10 -> redir_pc=0x00000000 (wrap); upd_valid=0.
- ext_flush during REDIR with redir_ready=1 in the same cycle -> redir_valid=0 next cycle, state IDLE, no second flush. With BRC_PERF_EN defined, perf_branches and perf_mispred match the totals from the preceding sequence.
